// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Control bundles are packed in the order the top-level output ports are listed.
package hazard_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
  localparam logic [STATE_W-1:0] ST_LU_STALL = 2'd1;
  localparam logic [STATE_W-1:0] ST_FLUSH    = 2'd2;
  localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the remaining-bubble counter; covers LOAD_LAT up to 7.
  localparam int unsigned LU_CNT_W = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                    idex_write: 1'b1, idex_bubble: 1'b0,
                                    exmem_write: 1'b1, exmem_flush: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_write: 1'b1, idex_bubble: 1'b1,
                                    exmem_write: 1'b1, exmem_flush: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                    idex_write: 1'b1, idex_bubble: 1'b1,
                                    exmem_write: 1'b1, exmem_flush: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_write: 1'b0, idex_bubble: 1'b0,
                                    exmem_write: 1'b0, exmem_flush: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                    idex_write: 1'b0, idex_bubble: 1'b1,
                                    exmem_write: 1'b0, exmem_flush: 1'b1};

  // Load in EX whose destination feeds a source of the instruction in ID; $0 never hazards.
  function automatic logic lu_hazard(input logic       memread,
                                     input logic [4:0] ex_rt,
                                     input logic [4:0] id_rs,
                                     input logic [4:0] id_rt,
                                     input logic       uses_rt);
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-wait freezes,
// plus saturating stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_memread,
  input  logic [4:0]         ex_rt,
  input  logic               mem_taken,
  input  logic               mem_stall_req,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               idex_write,
  output logic               idex_bubble,
  output logic               exmem_write,
  output logic               exmem_flush,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LOAD_LAT - 1);
  localparam logic [LU_CNT_W-1:0] LU_ONE  = LU_CNT_W'(1);

  logic [STATE_W-1:0]  r_state;
  logic [LU_CNT_W-1:0] r_lu_cnt;
  logic                r_resume;

  logic [STATE_W-1:0]  w_state_d;
  logic [STATE_W-1:0]  w_eff_state;
  logic [LU_CNT_W-1:0] w_lu_cnt_d;
  logic                w_resume_d;
  logic                w_stall_inc;
  logic                w_flush_inc;
  logic                w_lu_hit;
  ctrl_t               w_ctrl;
  ctrl_t               w_out;

  assign w_lu_hit = lu_hazard(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);

  // A released memory wait behaves as the state it interrupted in the same cycle.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == ST_MEM_WAIT) begin
      w_eff_state = r_resume ? ST_LU_STALL : ST_RUN;
    end
  end

  always_comb begin
    w_ctrl      = CTRL_RUN;
    w_state_d   = ST_RUN;
    w_lu_cnt_d  = r_lu_cnt;
    w_resume_d  = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;

    if (mem_stall_req) begin
      w_ctrl      = CTRL_FREEZE;
      w_state_d   = ST_MEM_WAIT;
      w_stall_inc = 1'b1;
      if ((r_state == ST_LU_STALL) && (r_lu_cnt != '0)) begin
        w_resume_d = 1'b1;
      end else if (r_state == ST_MEM_WAIT) begin
        w_resume_d = r_resume;
      end
    end else if (mem_taken) begin
      w_ctrl      = CTRL_FLUSH;
      w_state_d   = ST_FLUSH;
      w_lu_cnt_d  = '0;
      w_flush_inc = 1'b1;
    end else begin
      case (w_eff_state)
        ST_LU_STALL: begin
          w_ctrl      = CTRL_STALL;
          w_stall_inc = 1'b1;
          w_lu_cnt_d  = (r_lu_cnt != '0) ? (r_lu_cnt - LU_ONE) : '0;
          w_state_d   = (r_lu_cnt <= LU_ONE) ? ST_RUN : ST_LU_STALL;
        end
        ST_FLUSH: begin
          // IF/ID holds the flushed NOP, so any apparent hazard is stale.
          w_ctrl    = CTRL_RUN;
          w_state_d = ST_RUN;
        end
        default: begin
          if (w_lu_hit) begin
            w_ctrl      = CTRL_STALL;
            w_stall_inc = 1'b1;
            if (LOAD_LAT > 1) begin
              w_lu_cnt_d = LU_INIT;
              w_state_d  = ST_LU_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_lu_cnt <= '0;
      r_resume <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_lu_cnt <= w_lu_cnt_d;
      r_resume <= w_resume_d;
    end
  end

  assign w_out = rst ? w_ctrl : CTRL_RESET;

  assign pc_write    = w_out.pc_write;
  assign ifid_write  = w_out.ifid_write;
  assign ifid_flush  = w_out.ifid_flush;
  assign idex_write  = w_out.idex_write;
  assign idex_bubble = w_out.idex_bubble;
  assign exmem_write = w_out.exmem_write;
  assign exmem_flush = w_out.exmem_flush;
  assign state_o     = r_state;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (w_stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (w_flush_inc),
    .cnt   (flush_cnt)
  );

endmodule
